servo_pwm_sched: RTL
====================

SERVO_PWM_SCHED -- requirements
Module: servo_pwm_sched

Interface
REQ-001 Parameter N_CH, default 4, number of servo channels (1..8).
REQ-002 Parameter PERIOD_TICKS, default 800, frame length in ticks (800 x 25 us = 20 ms).
REQ-003 Parameter SLOT_TICKS, default PERIOD_TICKS/N_CH (200), channel start spacing in ticks.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-006 tick  input  1  one-clk timebase pulse, 40 kHz, from the clock divider.
REQ-007 en  input  1  scheduler enable.
REQ-008 wr_valid  input  1  width-update request.
REQ-009 wr_ready  output  1  update can be accepted.
REQ-010 wr_ch  input  3  target channel index.
REQ-011 wr_width  input  8  pulse width in ticks.
REQ-012 wr_err  output  1  one-clk pulse, invalid channel.
REQ-013 servo_pwm  output  N_CH  per-channel servo pulse outputs.
REQ-014 frame_start  output  1  one-clk pulse at each frame start.

Function
REQ-015 frame_cnt SHALL run 0..PERIOD_TICKS-1, advance only on clk with tick=1 and en=1, and wrap PERIOD_TICKS-1 -> 0.
REQ-016 en=0 SHALL hold frame_cnt at 0, force servo_pwm to 0 on the next clk, and copy shadow to active every clk.
REQ-017 Deassertion of en mid-pulse SHALL drive all outputs low on the next clk, and counting SHALL restart from 0 when en returns.
REQ-018 Channel i start SHALL be i*SLOT_TICKS; servo_pwm[i] SHALL be the registered value of (en && frame_cnt >= start_i && frame_cnt < start_i + active[i]), one clk latency.
REQ-019 Write transfer SHALL occur when wr_valid && wr_ready; wr_ready SHALL be 1 whenever rst_n=1.
REQ-020 Accepted write with wr_ch < N_CH SHALL load shadow[wr_ch] on the next clk; wr_ch >= N_CH SHALL change nothing and pulse wr_err for one clk.
REQ-021 active[] SHALL load from shadow[] only on the wrap tick (frame_cnt PERIOD_TICKS-1 -> 0), never mid-frame.
REQ-022 A write coinciding with the wrap tick SHALL update shadow only; active SHALL take the pre-write shadow value, and the new width SHALL apply from the following frame.
REQ-023 frame_start SHALL be 1 for exactly one clk, in the clk after each wrap and in the clk after the first tick following en 0 -> 1.
REQ-024 active[i]=0 SHALL keep servo_pwm[i] low for the whole frame.
REQ-025 Windows exceeding SLOT_TICKS MAY overlap the next channel's window.
REQ-026 Windows SHALL be truncated at PERIOD_TICKS-1, with no wrap into the next frame.

Reset
REQ-027 rst_n=0 SHALL asynchronously set frame_cnt=0, shadow[] and active[]=CENTER_TICKS (60), and servo_pwm, frame_start, wr_err, wr_ready=0.
REQ-028 After rst_n rises, wr_ready SHALL be 1 from the first clk.
REQ-029 Reset mid-pulse SHALL drop servo_pwm immediately, without waiting for a clock edge.

Configuration
REQ-030 With SERVO_CLAMP_EN defined, accepted wr_width SHALL be clamped to [MIN_TICKS=40, MAX_TICKS=80] before loading shadow.
REQ-031 Without SERVO_CLAMP_EN, wr_width SHALL be stored unmodified (0..255).

Structure
REQ-032 Package servo_pkg SHALL hold MIN_TICKS, MAX_TICKS, CENTER_TICKS, the default PERIOD_TICKS, and typedef width_t (8-bit).
REQ-033 Per-channel window compare SHALL be the sub-module servo_ch_cmp (inputs frame_cnt, start, width; output registered pulse), instantiated N_CH times.

Verification
REQ-034 Reset release, en=1, 800 ticks -> each servo_pwm[i] high for 60 ticks starting at tick i*200; frame_start once per 800 ticks.
REQ-035 Write ch2=75 at frame_cnt=100 -> ch2 stays 60 wide this frame and is 75 wide from the next frame.
REQ-036 Write ch1=70 on the wrap tick -> next frame ch1=60, the frame after ch1=70.
REQ-037 wr_ch=5 with N_CH=4 -> wr_err pulses once, all widths unchanged.
REQ-038 SERVO_CLAMP_EN: write 10 -> 40-tick pulse, write 200 -> 80-tick pulse; without the macro: write 0 -> no pulse, write 200 -> 200-tick pulse.
REQ-039 en dropped while ch0 high, then rst_n pulsed low mid-frame -> outputs low at the next clk and immediately on reset respectively; frame_cnt restarts at 0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, types and helpers for the servo PWM scheduler.
package servo_pkg;

    typedef logic [7:0] width_t;

    localparam int     DEFAULT_PERIOD_TICKS = 800;
    localparam width_t MIN_TICKS            = 8'd40;
    localparam width_t MAX_TICKS            = 8'd80;
    localparam width_t CENTER_TICKS         = 8'd60;

    // Limit a requested pulse width to the mechanically safe servo range.
    function automatic width_t clamp_width(input width_t w);
        width_t r;
        if (w < MIN_TICKS) begin
            r = MIN_TICKS;
        end else if (w > MAX_TICKS) begin
            r = MAX_TICKS;
        end else begin
            r = w;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_pwm_sched_if.sv
// Width-update write port of the servo PWM scheduler.
interface servo_wr_if;
    import servo_pkg::*;

    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_ch;
    width_t     wr_width;
    logic       wr_err;

    modport master (
        output wr_valid,
        output wr_ch,
        output wr_width,
        input  wr_ready,
        input  wr_err
    );

    modport slave (
        input  wr_valid,
        input  wr_ch,
        input  wr_width,
        output wr_ready,
        output wr_err
    );

endinterface

// File: rtl/servo_ch_cmp.sv
// Per-channel window comparator: pulse is high while frame_cnt lies in
// [start, start + width). The end is computed one bit wider than the
// counter so long windows are cut off by the frame end, never wrapped.
module servo_ch_cmp
    import servo_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] frame_cnt,
    input  logic [CNT_W-1:0] start,
    input  width_t           width,
    output logic             pulse
);

    localparam int EW = ((CNT_W > 8) ? CNT_W : 8) + 1;

    logic [EW-1:0] win_end;
    logic          in_win;

    // Decide whether the current count falls inside this channel's window.
    always_comb begin
        win_end = EW'(start) + EW'(width);
        if (en && (frame_cnt >= start) && (EW'(frame_cnt) < win_end)) begin
            in_win = 1'b1;
        end else begin
            in_win = 1'b0;
        end
    end

    // Register the window decision so the servo line is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= 1'b0;
        end else begin
            pulse <= in_win;
        end
    end

endmodule

// File: rtl/servo_pwm_sched.sv
// Multi-channel servo PWM scheduler. Channels start at staggered slots in
// a fixed-length frame; widths are written into a shadow bank and moved
// to the active bank only at the frame wrap (or continuously while
// disabled), so a pulse never changes length mid-frame.
// Optional build macro: SERVO_CLAMP_EN limits written widths to
// [MIN_TICKS, MAX_TICKS].
module servo_pwm_sched
    import servo_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int PERIOD_TICKS = DEFAULT_PERIOD_TICKS,
    parameter int SLOT_TICKS   = PERIOD_TICKS / N_CH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            en,
    servo_wr_if.slave       wr,
    output logic [N_CH-1:0] servo_pwm,
    output logic            frame_start
);

    localparam int               CNT_W    = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_TICKS - 1);

    logic [CNT_W-1:0] frame_cnt;
    logic             restart_pending;
    logic             wrap;
    logic             wr_fire;
    logic             ch_ok;
    width_t           wr_data;
    width_t           shadow [N_CH];
    width_t           active [N_CH];

    assign wrap = en && tick && (frame_cnt == LAST_CNT);

    // Decode the write request: handshake, channel range and stored width.
    always_comb begin
        wr_fire = wr.wr_valid && wr.wr_ready;
        ch_ok   = ({1'b0, wr.wr_ch} < 4'(N_CH));
`ifdef SERVO_CLAMP_EN
        wr_data = clamp_width(wr.wr_width);
`else
        wr_data = wr.wr_width;
`endif
    end

    // Frame counter and frame_start; a restart after enable or reset flags the first tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt       <= '0;
            restart_pending <= 1'b1;
            frame_start     <= 1'b0;
        end else if (!en) begin
            frame_cnt       <= '0;
            restart_pending <= 1'b1;
            frame_start     <= 1'b0;
        end else if (tick) begin
            if (frame_cnt == LAST_CNT) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            frame_start     <= wrap || restart_pending;
            restart_pending <= 1'b0;
        end else begin
            frame_start <= 1'b0;
        end
    end

    // Shadow bank: takes accepted in-range writes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= CENTER_TICKS;
            end
        end else if (wr_fire && ch_ok) begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr.wr_ch == 3'(i)) begin
                    shadow[i] <= wr_data;
                end
            end
        end
    end

    // Active bank: follows shadow at the wrap tick (pre-write value) or while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                active[i] <= CENTER_TICKS;
            end
        end else if (!en || wrap) begin
            for (int i = 0; i < N_CH; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // Write-port status: ready after the first clock, error pulse on bad channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr.wr_ready <= 1'b0;
            wr.wr_err   <= 1'b0;
        end else begin
            wr.wr_ready <= 1'b1;
            wr.wr_err   <= wr_fire && !ch_ok;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        localparam logic [CNT_W-1:0] START = CNT_W'(gi * SLOT_TICKS);

        servo_ch_cmp #(
            .CNT_W (CNT_W)
        ) u_cmp (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .frame_cnt (frame_cnt),
            .start     (START),
            .width     (active[gi]),
            .pulse     (servo_pwm[gi])
        );
    end

endmodule
